joy_md_scan_ctrl: RTL and testbench

- Single-clock scan sequencer for the Megadrive DB9 splitter.
- Time-multiplexes two pads through one 6-bit input using joy_split, and drives the MD select line through the 6-button protocol.
- Classifies each pad per frame as Master System, MD 3-button or MD 6-button.
- Publishes double-buffered, active-high 12-bit joystick words to the core's input mux.

---
 rtl/joy_md_pkg.sv | 41 ++++
 rtl/joy_md_port_decode.sv | 90 +++++++++
 rtl/joy_md_scan_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_joy_md_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_md_pkg.sv
// Shared constants and types for the Megadrive DB9 splitter scan sequencer.
// Provides scan step numbers, joystick word bit positions, the 12-bit word
// type, the sequencer state type and the active-low to active-high helper.
// Optional feature macro used by the top: JOY_MD_DEBOUNCE_EN.
package joy_md_pkg;

    // Scan steps (slot >> 1) that capture pad state.
    localparam logic [2:0] STEP_BASE = 3'd0;
    localparam logic [2:0] STEP_MDID = 3'd1;
    localparam logic [2:0] STEP_6ID  = 3'd5;
    localparam logic [2:0] STEP_XYZ  = 3'd6;

    // Published word layout, MSZYXCBAUDLR from bit 11 down to bit 0.
    localparam int BIT_R = 0;
    localparam int BIT_L = 1;
    localparam int BIT_D = 2;
    localparam int BIT_U = 3;
    localparam int BIT_A = 4;
    localparam int BIT_B = 5;
    localparam int BIT_C = 6;
    localparam int BIT_X = 7;
    localparam int BIT_Y = 8;
    localparam int BIT_Z = 9;
    localparam int BIT_S = 10;
    localparam int BIT_M = 11;

    localparam logic [3:0] SLOT_LAST = 4'd15;

    typedef logic [11:0] joy_word_t;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_GAP  = 1'b1
    } scan_state_t;

    // Pad lines are pulled up and pressed buttons short them to ground.
    function automatic logic [5:0] to_active_high(input logic [5:0] raw);
        return ~raw;
    endfunction

endpackage

// File: rtl/joy_md_port_decode.sv
// Per-port shadow decoder: builds one pad's 12-bit word and 6-button flag
// from the samples taken at each scan step of a frame.
// Ports: clk, reset (async, active-high), clear (wipe shadow at frame start),
//        sample (capture strobe for this port), step (current scan step),
//        joy_in (raw active-low lines), word (shadow word), six (6-button).
module joy_md_port_decode
    import joy_md_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       sample,
    input  logic [2:0] step,
    input  logic [5:0] joy_in,
    output joy_word_t  word,
    output logic       six
);

    logic [5:0] in_ah;
    joy_word_t  word_d;
    joy_word_t  word_q;
    logic       six_d;
    logic       six_q;

    assign in_ah = to_active_high(joy_in);

    always_comb begin
        word_d = word_q;
        six_d  = six_q;
        if (clear) begin
            word_d = '0;
            six_d  = 1'b0;
        end else if (sample) begin
            unique case (step)
                STEP_BASE: begin
                    word_d[BIT_U] = in_ah[3];
                    word_d[BIT_D] = in_ah[2];
                    word_d[BIT_L] = in_ah[1];
                    word_d[BIT_R] = in_ah[0];
                    word_d[BIT_B] = in_ah[4];
                    word_d[BIT_C] = in_ah[5];
                end
                STEP_MDID: begin
                    // An MD pad grounds L and R while select is low;
                    // a Master System pad ignores select entirely.
                    if (in_ah[1:0] == 2'b11) begin
                        word_d[BIT_A] = in_ah[4];
                        word_d[BIT_S] = in_ah[5];
                    end else begin
                        word_d[BIT_A] = 1'b0;
                        word_d[BIT_S] = 1'b0;
                    end
                end
                STEP_6ID: begin
                    // Third low pulse: a 6-button pad grounds all of UDLR.
                    six_d = &in_ah[3:0];
                end
                STEP_XYZ: begin
                    if (six_q) begin
                        word_d[BIT_M] = in_ah[0];
                        word_d[BIT_X] = in_ah[1];
                        word_d[BIT_Y] = in_ah[2];
                        word_d[BIT_Z] = in_ah[3];
                    end else begin
                        word_d[BIT_M] = 1'b0;
                        word_d[BIT_X] = 1'b0;
                        word_d[BIT_Y] = 1'b0;
                        word_d[BIT_Z] = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            six_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            six_q  <= six_d;
        end
    end

    assign word = word_q;
    assign six  = six_q;

endmodule

// File: rtl/joy_md_scan_ctrl.sv
// Scan sequencer for the Megadrive DB9 splitter: walks 16 slots alternating
// between the two ports, drives the MD select line through the 6-button
// protocol, then idles for a gap and publishes both pads atomically.
// Ports: clk, reset (async, active-high), joy_in (raw active-low lines),
//        joy_mdsel (select to pads), joy_split (0 = port 1, 1 = port 2),
//        joystick1/2 (active-high MSZYXCBAUDLR), six_btn1/2 (6-button
//        detected), frame_valid (one-clock publish pulse).
// Define JOY_MD_DEBOUNCE_EN to publish a port only when its word matches
// the previous frame's word.
module joy_md_scan_ctrl
    import joy_md_pkg::*;
#(
    parameter int SLOT_CYCLES = 64,
    parameter int GAP_CYCLES  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  joy_in,
    output logic        joy_mdsel,
    output logic        joy_split,
    output logic [11:0] joystick1,
    output logic [11:0] joystick2,
    output logic        six_btn1,
    output logic        six_btn2,
    output logic        frame_valid
);

    localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

    scan_state_t      state_d;
    scan_state_t      state_q;
    logic [CYC_W-1:0] cyc_d;
    logic [CYC_W-1:0] cyc_q;
    logic [3:0]       slot_d;
    logic [3:0]       slot_q;
    logic [GAP_W-1:0] gap_d;
    logic [GAP_W-1:0] gap_q;
    logic             mdsel_d;
    logic             mdsel_q;
    logic             split_d;
    logic             split_q;
    joy_word_t        joy1_d;
    joy_word_t        joy1_q;
    joy_word_t        joy2_d;
    joy_word_t        joy2_q;
    logic             six1_d;
    logic             six1_q;
    logic             six2_d;
    logic             six2_q;
    logic             fv_d;
    logic             fv_q;
`ifdef JOY_MD_DEBOUNCE_EN
    logic [12:0]      prev1_d;
    logic [12:0]      prev1_q;
    logic [12:0]      prev2_d;
    logic [12:0]      prev2_q;
`endif

    logic       slot_end;
    logic [3:0] slot_nxt;
    logic       sh_clear;
    logic       samp1;
    logic       samp2;
    joy_word_t  sh_word1;
    joy_word_t  sh_word2;
    logic       sh_six1;
    logic       sh_six2;

    assign slot_end = (state_q == ST_SCAN) && (cyc_q == CYC_LAST);
    assign slot_nxt = slot_q + 4'd1;
    assign sh_clear = (state_q == ST_SCAN) && (slot_q == 4'd0) &&
                      (cyc_q == '0);
    assign samp1    = slot_end && !slot_q[0];
    assign samp2    = slot_end && slot_q[0];

    joy_md_port_decode u_port1 (
        .clk    (clk),
        .reset  (reset),
        .clear  (sh_clear),
        .sample (samp1),
        .step   (slot_q[3:1]),
        .joy_in (joy_in),
        .word   (sh_word1),
        .six    (sh_six1)
    );

    joy_md_port_decode u_port2 (
        .clk    (clk),
        .reset  (reset),
        .clear  (sh_clear),
        .sample (samp2),
        .step   (slot_q[3:1]),
        .joy_in (joy_in),
        .word   (sh_word2),
        .six    (sh_six2)
    );

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        slot_d  = slot_q;
        gap_d   = gap_q;
        mdsel_d = mdsel_q;
        split_d = split_q;
        joy1_d  = joy1_q;
        joy2_d  = joy2_q;
        six1_d  = six1_q;
        six2_d  = six2_q;
        fv_d    = 1'b0;
`ifdef JOY_MD_DEBOUNCE_EN
        prev1_d = prev1_q;
        prev2_d = prev2_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (slot_end) begin
                    cyc_d = '0;
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_GAP;
                        slot_d  = 4'd0;
                        gap_d   = '0;
                        mdsel_d = 1'b1;
                        split_d = 1'b0;
                    end else begin
                        // Outputs lead the slot so they are valid from
                        // its first clock through the sample clock.
                        slot_d  = slot_nxt;
                        split_d = slot_nxt[0];
                        mdsel_d = ~slot_nxt[1];
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_SCAN;
                    gap_d   = '0;
                    cyc_d   = '0;
                    slot_d  = 4'd0;
                    mdsel_d = 1'b1;
                    split_d = 1'b0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
                // The first gap clock is the publish clock.
                if (gap_q == '0) begin
                    fv_d = 1'b1;
`ifdef JOY_MD_DEBOUNCE_EN
                    prev1_d = {sh_six1, sh_word1};
                    prev2_d = {sh_six2, sh_word2};
                    if ({sh_six1, sh_word1} == prev1_q) begin
                        joy1_d = sh_word1;
                        six1_d = sh_six1;
                    end
                    if ({sh_six2, sh_word2} == prev2_q) begin
                        joy2_d = sh_word2;
                        six2_d = sh_six2;
                    end
`else
                    joy1_d = sh_word1;
                    joy2_d = sh_word2;
                    six1_d = sh_six1;
                    six2_d = sh_six2;
`endif
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            cyc_q   <= '0;
            slot_q  <= 4'd0;
            gap_q   <= '0;
            mdsel_q <= 1'b1;
            split_q <= 1'b0;
            joy1_q  <= '0;
            joy2_q  <= '0;
            six1_q  <= 1'b0;
            six2_q  <= 1'b0;
            fv_q    <= 1'b0;
`ifdef JOY_MD_DEBOUNCE_EN
            prev1_q <= '0;
            prev2_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            slot_q  <= slot_d;
            gap_q   <= gap_d;
            mdsel_q <= mdsel_d;
            split_q <= split_d;
            joy1_q  <= joy1_d;
            joy2_q  <= joy2_d;
            six1_q  <= six1_d;
            six2_q  <= six2_d;
            fv_q    <= fv_d;
`ifdef JOY_MD_DEBOUNCE_EN
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
`endif
        end
    end

    assign joy_mdsel   = mdsel_q;
    assign joy_split   = split_q;
    assign joystick1   = joy1_q;
    assign joystick2   = joy2_q;
    assign six_btn1    = six1_q;
    assign six_btn2    = six2_q;
    assign frame_valid = fv_q;

endmodule

// File: tb/tb_joy_md_scan_ctrl.sv
// Bench for joy_md_scan_ctrl: pad models on both splitter ports, a
// frame-level reference model, vector table, timing and reset sequences.
module tb_joy_md_scan_ctrl;

    localparam int SC = 8;
    localparam int GC = 32;
    localparam int PERIOD = 16 * SC + GC + 1;

    localparam int P_NONE = 0;
    localparam int P_SMS  = 1;
    localparam int P_MD3  = 2;
    localparam int P_MD6  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  joy_in;
    logic        joy_mdsel;
    logic        joy_split;
    logic [11:0] joystick1;
    logic [11:0] joystick2;
    logic        six_btn1;
    logic        six_btn2;
    logic        frame_valid;

    int n_vec = 0;
    int n_err = 0;

    int          pt [2];
    logic [11:0] pb [2];

    logic [12:0] m_out  [2];
    logic [12:0] m_prev [2];

    logic sel_prev = 1'b1;
    int   idle = 0;
    int   lows = 0;

    typedef struct {
        int          t1;
        logic [11:0] b1;
        int          t2;
        logic [11:0] b2;
        logic [11:0] e1;
        logic [11:0] e2;
        logic        s1;
        logic        s2;
    } vec_t;

    vec_t vt [8];

    joy_md_scan_ctrl #(
        .SLOT_CYCLES (SC),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .joy_mdsel   (joy_mdsel),
        .joy_split   (joy_split),
        .joystick1   (joystick1),
        .joystick2   (joystick2),
        .six_btn1    (six_btn1),
        .six_btn2    (six_btn2),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    // Pad-side select tracker: counts low pulses, forgets after long idle.
    always @(negedge clk) begin
        sel_prev <= joy_mdsel;
        if (joy_mdsel != sel_prev) idle <= 0;
        else if (idle < 1000) idle <= idle + 1;
        if (idle > 24 && joy_mdsel) lows <= 0;
        else if (sel_prev && !joy_mdsel) lows <= lows + 1;
    end

    // Button vector b uses the published layout; returns active-low lines.
    function automatic logic [5:0] pad_lines(input int t, input logic [11:0] b,
                                             input logic sel, input int n);
        logic [5:0] a;
        a = 6'b0;
        if (t == P_SMS) begin
            a = {b[6], b[5], b[3], b[2], b[1], b[0]};
        end else if (t == P_MD3 || t == P_MD6) begin
            if (sel) begin
                if (t == P_MD6 && n == 3) a = {b[6], b[5], b[9], b[8], b[7], b[11]};
                else a = {b[6], b[5], b[3], b[2], b[1], b[0]};
            end else begin
                if (t == P_MD6 && n == 3) a = {b[10], b[4], 4'b1111};
                else a = {b[10], b[4], b[3], b[2], 2'b11};
            end
        end
        return ~a;
    endfunction

    always_comb begin
        if (joy_split) joy_in = pad_lines(pt[1], pb[1], joy_mdsel, lows);
        else joy_in = pad_lines(pt[0], pb[0], joy_mdsel, lows);
    end

    function automatic logic [11:0] ref_word(input int t, input logic [11:0] b);
        case (t)
            P_SMS:   return b & 12'h06F;
            P_MD3:   return b & 12'h47F;
            P_MD6:   return b;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_out[p]  = '0;
            m_prev[p] = '0;
        end
    endtask

    task automatic model_frame();
        logic [12:0] cand;
        for (int p = 0; p < 2; p++) begin
            cand = {pt[p] == P_MD6, ref_word(pt[p], pb[p])};
`ifdef JOY_MD_DEBOUNCE_EN
            if (cand == m_prev[p]) m_out[p] = cand;
            m_prev[p] = cand;
`else
            m_out[p] = cand;
`endif
        end
    endtask

    task automatic chk(input string name, input logic [11:0] got,
                       input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_j1"}, joystick1, 12'h000);
        chk({tag, "_j2"}, joystick2, 12'h000);
        chk({tag, "_six1"}, 12'(six_btn1), 12'h000);
        chk({tag, "_six2"}, 12'(six_btn2), 12'h000);
        chk({tag, "_fv"}, 12'(frame_valid), 12'h000);
        chk({tag, "_mdsel"}, 12'(joy_mdsel), 12'h001);
        chk({tag, "_split"}, 12'(joy_split), 12'h000);
    endtask

    task automatic wait_fv(output int cyc);
        bit ok;
        cyc = 0;
        ok = 0;
        while (!ok && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_valid) ok = 1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL fv_timeout: got no frame_valid, expected one within 400 clocks");
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_j1"}, joystick1, m_out[0][11:0]);
        chk({tag, "_j2"}, joystick2, m_out[1][11:0]);
        chk({tag, "_six1"}, 12'(six_btn1), 12'(m_out[0][12]));
        chk({tag, "_six2"}, 12'(six_btn2), 12'(m_out[1][12]));
    endtask

    initial begin
        int c;
        int t;
        logic [11:0] b;

        vt[0] = '{P_NONE, 12'hFFF, P_NONE, 12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0};
        vt[1] = '{P_MD3,  12'h408, P_NONE, 12'h000, 12'h408, 12'h000, 1'b0, 1'b0};
        vt[2] = '{P_NONE, 12'h000, P_MD6,  12'h280, 12'h000, 12'h280, 1'b0, 1'b1};
        vt[3] = '{P_SMS,  12'h020, P_NONE, 12'h000, 12'h020, 12'h000, 1'b0, 1'b0};
        vt[4] = '{P_SMS,  12'h415, P_MD3,  12'h047, 12'h005, 12'h047, 1'b0, 1'b0};
        vt[5] = '{P_MD3,  12'h473, P_MD6,  12'hFFF, 12'h473, 12'hFFF, 1'b0, 1'b1};
        vt[6] = '{P_MD6,  12'h800, P_MD3,  12'h004, 12'h800, 12'h004, 1'b1, 1'b0};
        vt[7] = '{P_MD6,  12'h000, P_SMS,  12'h00A, 12'h000, 12'h00A, 1'b1, 1'b0};

        pt[0] = P_NONE;
        pt[1] = P_NONE;
        pb[0] = '0;
        pb[1] = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset = 1'b0;

        // Slot timing of the first frame after reset release.
        for (int k = 1; k <= 140; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("fv_k%0d", k), 12'(frame_valid), 12'(k == 129));
            chk($sformatf("split_k%0d", k), 12'(joy_split),
                (k < 128) ? 12'((k >> 3) & 1) : 12'h000);
            chk($sformatf("mdsel_k%0d", k), 12'(joy_mdsel),
                (k < 128) ? 12'(~(k >> 4) & 1) : 12'h001);
            if (k == 129) begin
                model_frame();
                chk_model("idle_frame");
            end
        end

        foreach (vt[i]) begin
            pt[0] = vt[i].t1;
            pb[0] = vt[i].b1;
            pt[1] = vt[i].t2;
            pb[1] = vt[i].b2;
            wait_fv(c);
            model_frame();
`ifdef JOY_MD_DEBOUNCE_EN
            wait_fv(c);
            model_frame();
`endif
            chk($sformatf("vec%0d_j1", i), joystick1, vt[i].e1);
            chk($sformatf("vec%0d_j2", i), joystick2, vt[i].e2);
            chk($sformatf("vec%0d_six1", i), 12'(six_btn1), 12'(vt[i].s1));
            chk($sformatf("vec%0d_six2", i), 12'(six_btn2), 12'(vt[i].s2));
        end

        // Reset in slot 9 (port 2, step 4), then one full first frame.
        repeat (16 * 0 + GC + 72) @(posedge clk);
        #1;
        chk("slot9_split", 12'(joy_split), 12'h001);
        chk("slot9_j2_live", joystick2, 12'h00A);
        reset = 1'b1;
        #1;
        chk_reset("midrst");
        repeat (30) @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_fv(c);
        chk("post_reset_fv_delay", 12'(c), 12'(129));
        model_frame();
        chk_model("post_reset");

        for (int r = 0; r < 25; r++) begin
            for (int p = 0; p < 2; p++) begin
                t = int'($urandom_range(0, 3));
                b = 12'($urandom);
                if (t == P_SMS && b[0] && b[1]) b[1] = 1'b0;
                if (t == P_MD3 && b[2] && b[3]) b[2] = 1'b0;
                pt[p] = t;
                pb[p] = b;
            end
            wait_fv(c);
            chk($sformatf("rnd%0d_period", r), 12'(c), 12'(PERIOD));
            model_frame();
            chk_model($sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
